// File: rtl/minx16_dbus_pkg.sv
// Shared types and constants for the Minx16 dbus target.
// Covers the bus widths, the FSM and transfer-direction enums, and the byte-lane mask helper.
package minx16_dbus_pkg;

    localparam int AD_W  = 16;
    localparam int STB_W = 2;

    // Pad-enable value that leaves every AD line released (pad-oeb sense).
    localparam logic [AD_W-1:0] AD_RELEASED = 16'hFFFF;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SEL,
        ST_WAIT,
        ST_RESP
    } state_t;

    typedef enum logic [1:0] {
        DIR_RD,
        DIR_WR,
        DIR_ERR
    } dir_t;

    function automatic logic [AD_W-1:0] lane_mask(input logic [STB_W-1:0] stb);
        return {{8{stb[1]}}, {8{stb[0]}}};
    endfunction

endpackage

// File: rtl/minx16_regfile.sv
// Byte-writable register file with async clear.
// One read port feeds the bus-side output register; the other is a combinational debug tap.
module minx16_regfile
    import minx16_dbus_pkg::*;
#(
    parameter int ADDR_BITS = 4
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic [STB_W-1:0]     wr_stb,
    input  logic [ADDR_BITS-1:0] wr_addr,
    input  logic [AD_W-1:0]      wr_data,
    input  logic [ADDR_BITS-1:0] rd_addr,
    output logic [AD_W-1:0]      rd_data,
    input  logic [ADDR_BITS-1:0] dbg_addr,
    output logic [AD_W-1:0]      dbg_data
);

    localparam int DEPTH = 1 << ADDR_BITS;

    logic [AD_W-1:0] words [DEPTH];
    logic [AD_W-1:0] mask;

    assign mask = lane_mask(wr_stb);

    // NOTE: the file is small and must read back as zero after reset, so it is built
    // from resettable flops rather than a RAM macro; every word is cleared explicitly.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < DEPTH; i++) begin
                words[i] <= '0;
            end
        end else if (wr_stb != '0) begin
            words[wr_addr] <= (words[wr_addr] & ~mask) | (wr_data & mask);
        end
    end

    assign rd_data  = words[rd_addr];
    assign dbg_data = words[dbg_addr];

endmodule

// File: rtl/minx16_dbus_target.sv
// Minx16 dbus responder: window decode, wait states, rdy handshake and read drive.
// The top word of the register file doubles as a mailbox that raises intr_o.
module minx16_dbus_target
    import minx16_dbus_pkg::*;
#(
    parameter logic [15:0] BASE      = 16'hF000,
    parameter int          ADDR_BITS = 4,
    parameter int          WAIT      = 1
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic [AD_W-1:0]      ad_i,
    output logic [AD_W-1:0]      ad_o,
    output logic [AD_W-1:0]      ad_e,
    input  logic                 ale_i,
    input  logic [STB_W-1:0]     stb_i,
    input  logic                 rd_i,
    input  logic                 wr_i,
    output logic                 rdy_o,
    output logic                 rdy_e,
    output logic                 intr_o,
    input  logic                 inta_i,
    output logic                 err_o,
    input  logic [ADDR_BITS-1:0] dbg_addr_i,
    output logic [AD_W-1:0]      dbg_data_o
);

    localparam logic [3:0] WAIT_CNT = 4'(WAIT);
    localparam logic [ADDR_BITS-1:0] MBOX_ADDR = '1;

    state_t                 state, state_next;
    dir_t                   dir_q, dir_next;
    logic [ADDR_BITS-1:0]   addr_q, addr_next;
    logic [STB_W-1:0]       stb_q, stb_next;
    logic [3:0]             cnt_q, cnt_next;

    logic                   hit;
    logic                   resp_next;
    logic                   read_next;
    logic [STB_W-1:0]       wr_stb;
    logic                   mbox_set;
    logic [AD_W-1:0]        rd_data;

    assign hit = ale_i && (ad_i[AD_W-1:ADDR_BITS] == BASE[AD_W-1:ADDR_BITS]);

    // NOTE: every output of this block gets a default first, so no path leaves a
    // signal unassigned and no latch is inferred.
    always_comb begin
        state_next = state;
        dir_next   = dir_q;
        addr_next  = addr_q;
        stb_next   = stb_q;
        cnt_next   = cnt_q;
        unique case (state)
            ST_IDLE: begin
                if (hit) begin
                    addr_next  = ad_i[ADDR_BITS-1:0];
                    stb_next   = stb_i;
                    state_next = ST_SEL;
                end
            end
            ST_SEL: begin
                if (ale_i) begin
                    if (hit) begin
                        addr_next = ad_i[ADDR_BITS-1:0];
                        stb_next  = stb_i;
                    end else begin
                        state_next = ST_IDLE;
                    end
                end else if (rd_i || wr_i) begin
                    if (rd_i && wr_i) begin
                        dir_next = DIR_ERR;
                    end else if (rd_i) begin
                        dir_next = DIR_RD;
                    end else begin
                        dir_next = DIR_WR;
                    end
                    cnt_next   = WAIT_CNT;
                    state_next = (WAIT == 0) ? ST_RESP : ST_WAIT;
                end
            end
            ST_WAIT: begin
                cnt_next = cnt_q - 4'd1;
                if (cnt_q <= 4'd1) begin
                    state_next = ST_RESP;
                end
            end
            ST_RESP: begin
                state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples
    // the pre-edge values, independent of statement order.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state  <= ST_IDLE;
            dir_q  <= DIR_RD;
            addr_q <= '0;
            stb_q  <= '0;
            cnt_q  <= '0;
        end else begin
            state  <= state_next;
            dir_q  <= dir_next;
            addr_q <= addr_next;
            stb_q  <= stb_next;
            cnt_q  <= cnt_next;
        end
    end

    // Write data is taken at the edge that ends RESP, while the CPU still holds it.
    assign wr_stb   = (state == ST_RESP && dir_q == DIR_WR) ? stb_q : '0;
    assign mbox_set = (wr_stb != '0) && (addr_q == MBOX_ADDR);

    minx16_regfile #(
        .ADDR_BITS (ADDR_BITS)
    ) u_regfile (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .wr_stb   (wr_stb),
        .wr_addr  (addr_q),
        .wr_data  (ad_i),
        .rd_addr  (addr_q),
        .rd_data  (rd_data),
        .dbg_addr (dbg_addr_i),
        .dbg_data (dbg_data_o)
    );

    // Outputs are registered from the next state so they are valid throughout RESP.
    assign resp_next = (state_next == ST_RESP);
    assign read_next = resp_next && (dir_next == DIR_RD);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            ad_o   <= '0;
            ad_e   <= AD_RELEASED;
            rdy_o  <= 1'b0;
            rdy_e  <= 1'b1;
            err_o  <= 1'b0;
            intr_o <= 1'b0;
        end else begin
            rdy_o <= resp_next;
            rdy_e <= !resp_next;
            err_o <= resp_next && (dir_next == DIR_ERR);
            if (read_next) begin
                ad_o <= rd_data;
                ad_e <= '0;
            end else begin
                ad_o <= '0;
                ad_e <= AD_RELEASED;
            end
            if (mbox_set) begin
                intr_o <= 1'b1;
            end else if (inta_i) begin
                intr_o <= 1'b0;
            end
        end
    end

endmodule
